// File: rtl/array111_regpar_init.sv
// array111_regpar_init: single-clock 1W/1R register array with per-lane parity,
// parity error injection, first-error capture (address + lane mask) and a
// hardware init sweep that fills every word with INIT_VAL after reset.
// The storage arrays themselves are never reset, so they can map to LUT/RAM.
// The registered read data port is named dout because "do" is a keyword.
module array111_regpar_init #(
    parameter int                ADDRBIT  = 9,
    parameter int                DEPTH    = 512,
    parameter int                WIDTH    = 32,
    parameter int                LANEW    = 8,
    parameter int                BYPASS   = 0,
    parameter logic [WIDTH-1:0]  INIT_VAL = '0,
    localparam int               NLANE    = WIDTH / LANEW
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               init_req,
    output logic               init_busy,
    input  logic               we,
    input  logic [ADDRBIT-1:0] wa,
    input  logic [WIDTH-1:0]   di,
    input  logic               re,
    input  logic [ADDRBIT-1:0] ra,
    output logic [WIDTH-1:0]   dout,
    output logic               dvld,
    input  logic [1:0]         par_ctrl,
    output logic               par_err,
    output logic [NLANE-1:0]   par_err_lane,
    output logic [ADDRBIT-1:0] par_err_addr
);

    // Reject illegal geometry at elaboration time.
    generate
        if ((WIDTH % LANEW) != 0 || DEPTH > (1 << ADDRBIT)) begin : g_param_check
            $fatal(1, "array111_regpar_init: WIDTH must be a multiple of LANEW and DEPTH <= 2**ADDRBIT");
        end
    endgenerate

    // DEPTH widened by one bit so DEPTH == 2**ADDRBIT still compares correctly.
    localparam logic [ADDRBIT:0]   DEPTH_EXT = (ADDRBIT + 1)'(DEPTH);
    localparam logic [ADDRBIT-1:0] LAST_PTR  = ADDRBIT'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t             state_reg;
    logic [ADDRBIT-1:0] ptr_reg;
    logic               init_busy_reg;

    // Storage: data words and one parity bit per lane, both without reset.
    logic [WIDTH-1:0]   mem   [DEPTH];
    logic [NLANE-1:0]   par_mem [DEPTH];

    // Read-side registers: data, stored parity and address travel together.
    logic [WIDTH-1:0]   do_reg;
    logic               dvld_reg;
    logic               chk_reg;
    logic [NLANE-1:0]   rpar_reg;
    logic [ADDRBIT-1:0] ra_reg;

    logic               par_err_reg;
    logic [NLANE-1:0]   par_err_lane_reg;
    logic [ADDRBIT-1:0] par_err_addr_reg;

    logic [NLANE-1:0]   di_par;
    logic [NLANE-1:0]   init_par;
    logic [NLANE-1:0]   do_par;
    logic [NLANE-1:0]   wr_par;
    logic [NLANE-1:0]   mismatch;
    logic               err_hit;
    logic               init_active;
    logic               wa_ok;
    logic               ra_ok;

    logic               mem_we;
    logic [ADDRBIT-1:0] mem_wa;
    logic [WIDTH-1:0]   mem_wd;
    logic [NLANE-1:0]   mem_wp;

    // Per-lane even parity of write data, init value and registered read data.
    generate
        for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane_par
            assign di_par[gi]   = ^di[gi*LANEW +: LANEW];
            assign init_par[gi] = ^INIT_VAL[gi*LANEW +: LANEW];
            assign do_par[gi]   = ^do_reg[gi*LANEW +: LANEW];
        end
    endgenerate

    assign init_active = (state_reg == ST_INIT);
    assign wa_ok       = ({1'b0, wa} < DEPTH_EXT);
    assign ra_ok       = ({1'b0, ra} < DEPTH_EXT);
    // Injection flips every lane's stored parity bit.
    assign wr_par      = di_par ^ {NLANE{par_ctrl[1]}};

    // Write-port mux: the init sweep owns the port, user writes only when idle.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = ptr_reg;
        mem_wd = INIT_VAL;
        mem_wp = init_par;
        if (rst_) begin
            if (init_active) begin
                mem_we = 1'b1;
            end else if (we && wa_ok) begin
                mem_we = 1'b1;
                mem_wa = wa;
                mem_wd = di;
                mem_wp = wr_par;
            end
        end
    end

    // Array write, no reset so storage can infer as RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa]     <= mem_wd;
            par_mem[mem_wa] <= mem_wp;
        end
    end

    // Init sweep FSM: walks ptr across every word once, then idles.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_reg     <= ST_INIT;
            ptr_reg       <= '0;
            init_busy_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (ptr_reg == LAST_PTR) begin
                        state_reg     <= ST_IDLE;
                        init_busy_reg <= 1'b0;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                default: begin
                    if (init_req) begin
                        state_reg     <= ST_INIT;
                        ptr_reg       <= '0;
                        init_busy_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Registered read; out-of-range reads return zero and skip the parity check.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            do_reg   <= '0;
            dvld_reg <= 1'b0;
            chk_reg  <= 1'b0;
            rpar_reg <= '0;
            ra_reg   <= '0;
        end else if (init_active || !re) begin
            dvld_reg <= 1'b0;
            chk_reg  <= 1'b0;
        end else begin
            dvld_reg <= 1'b1;
            ra_reg   <= ra;
            if (ra_ok) begin
                chk_reg <= 1'b1;
                if (BYPASS != 0 && we && wa == ra) begin
                    do_reg   <= di;
                    rpar_reg <= wr_par;
                end else begin
                    do_reg   <= mem[ra];
                    rpar_reg <= par_mem[ra];
                end
            end else begin
                chk_reg  <= 1'b0;
                do_reg   <= '0;
                rpar_reg <= '0;
            end
        end
    end

    assign mismatch = do_par ^ rpar_reg;
    assign err_hit  = dvld_reg && chk_reg && (|mismatch);

    // Sticky error with first-error capture; clear has priority over a new error.
    always_ff @(posedge clk) begin
        if (!rst_ || par_ctrl[0]) begin
            par_err_reg      <= 1'b0;
            par_err_lane_reg <= '0;
            par_err_addr_reg <= '0;
        end else if (err_hit && !par_err_reg) begin
            par_err_reg      <= 1'b1;
            par_err_lane_reg <= mismatch;
            par_err_addr_reg <= ra_reg;
        end
    end

    assign init_busy    = init_busy_reg;
    assign dout         = do_reg;
    assign dvld         = dvld_reg;
    assign par_err      = par_err_reg;
    assign par_err_lane = par_err_lane_reg;
    assign par_err_addr = par_err_addr_reg;

endmodule

// File: tb/tb_array111_regpar_init.sv
// Directed bench for array111_regpar_init: reads push expected data into a
// scoreboard queue, a negedge monitor pops and compares on every dvld.
// Two instances share stimulus: dut0 with BYPASS=0, dut1 with BYPASS=1.
module tb_array111_regpar_init;

    localparam int          ADDRBIT  = 9;
    localparam int          DEPTH    = 300;
    localparam int          WIDTH    = 32;
    localparam int          LANEW    = 8;
    localparam int          NLANE    = WIDTH / LANEW;
    localparam logic [31:0] INIT_VAL = 32'hC3A5_0F16;

    logic               clk = 1'b0;
    logic               rst_;
    logic               init_req;
    logic               we;
    logic [ADDRBIT-1:0] wa;
    logic [WIDTH-1:0]   di;
    logic               re;
    logic [ADDRBIT-1:0] ra;
    logic [1:0]         par_ctrl;

    logic               init_busy, init_busy1;
    logic [WIDTH-1:0]   dout, dout1;
    logic               dvld, dvld1;
    logic               par_err, par_err1;
    logic [NLANE-1:0]   par_err_lane, par_err_lane1;
    logic [ADDRBIT-1:0] par_err_addr, par_err_addr1;

    int                 n_pass = 0;
    int                 n_total = 0;
    logic [31:0]        model [DEPTH];
    logic [31:0]        exp_q [$];
    logic [31:0]        mon_exp;
    logic [31:0]        last_do;
    int                 cnt;

    always #5 clk = ~clk;

    array111_regpar_init #(
        .ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH), .LANEW(LANEW),
        .BYPASS(0), .INIT_VAL(INIT_VAL)
    ) dut0 (
        .clk(clk), .rst_(rst_), .init_req(init_req), .init_busy(init_busy),
        .we(we), .wa(wa), .di(di), .re(re), .ra(ra), .dout(dout), .dvld(dvld),
        .par_ctrl(par_ctrl), .par_err(par_err), .par_err_lane(par_err_lane),
        .par_err_addr(par_err_addr)
    );

    array111_regpar_init #(
        .ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH), .LANEW(LANEW),
        .BYPASS(1), .INIT_VAL(INIT_VAL)
    ) dut1 (
        .clk(clk), .rst_(rst_), .init_req(init_req), .init_busy(init_busy1),
        .we(we), .wa(wa), .di(di), .re(re), .ra(ra), .dout(dout1), .dvld(dvld1),
        .par_ctrl(par_ctrl), .par_err(par_err1), .par_err_lane(par_err_lane1),
        .par_err_addr(par_err_addr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDRBIT-1:0] a, input logic [31:0] d, input logic inj);
        we = 1'b1; wa = a; di = d; par_ctrl = {inj, 1'b0};
        tick();
        we = 1'b0; par_ctrl = 2'b00;
        if (a < DEPTH) model[a] = d;
        $display("write addr=%0d data=%h inject=%0d", a, d, inj);
    endtask

    task automatic rd(input logic [ADDRBIT-1:0] a);
        re = 1'b1; ra = a;
        exp_q.push_back((a < DEPTH) ? model[a] : 32'h0);
        tick();
        re = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 4 * DEPTH) begin
            tick();
            n++;
        end
    endtask

    // Scoreboard monitor: every dvld pulse must match the oldest queued read.
    always @(negedge clk) begin
        if (dvld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_dvld", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_do", dout, mon_exp);
                $display("read data=%h expected=%h", dout, mon_exp);
            end
        end
    end

    initial begin
        rst_ = 1'b0; init_req = 1'b0; we = 1'b0; re = 1'b0;
        wa = '0; ra = '0; di = '0; par_ctrl = 2'b00;
        for (int i = 0; i < DEPTH; i++) model[i] = INIT_VAL;
        tick();
        tick();

        // T1: reset values, sweep length, every word reads INIT_VAL
        check("rst_do", dout, 32'h0);
        check("rst_dvld", 32'(dvld), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        check("rst_lane", 32'(par_err_lane), 32'd0);
        check("rst_addr", 32'(par_err_addr), 32'd0);
        check("rst_busy", 32'(init_busy), 32'd1);
        rst_ = 1'b1;
        wait_busy(cnt);
        check("t1_busy_cycles", 32'(cnt), 32'(DEPTH));
        for (int a = 0; a < DEPTH; a++) rd(ADDRBIT'(a));
        tick(); tick(); tick();
        check("t1_no_err", 32'(par_err), 32'd0);

        // Out-of-range write is ignored, out-of-range read returns zero
        wr(9'd400, 32'hFFFF_0000, 1'b0);
        rd(9'd144);
        rd(9'd400);
        check("oor_dvld", 32'(dvld), 32'd1);
        tick(); tick();
        check("oor_no_err", 32'(par_err), 32'd0);

        // T2: write then read, latency one, dvld a single-cycle pulse
        wr(9'd5, 32'h1234_5678, 1'b0);
        re = 1'b1; ra = 9'd5; exp_q.push_back(model[5]);
        tick();
        re = 1'b0;
        check("t2_dvld", 32'(dvld), 32'd1);
        check("t2_do", dout, 32'h1234_5678);
        tick();
        check("t2_dvld_pulse", 32'(dvld), 32'd0);
        check("t2_do_hold", dout, 32'h1234_5678);

        // T3: injected error captured, later error leaves capture frozen
        wr(9'd7, 32'h0000_00FF, 1'b1);
        rd(9'd7);
        tick();
        check("t3_err", 32'(par_err), 32'd1);
        check("t3_lane", 32'(par_err_lane), 32'hF);
        check("t3_addr", 32'(par_err_addr), 32'd7);
        wr(9'd9, 32'h0000_0001, 1'b1);
        rd(9'd9);
        tick(); tick();
        check("t3_err_sticky", 32'(par_err), 32'd1);
        check("t3_addr_frozen", 32'(par_err_addr), 32'd7);
        check("t3_lane_frozen", 32'(par_err_lane), 32'hF);

        // T4: clear wins over a same-cycle error, clean rewrites stay clean
        rd(9'd9);
        par_ctrl = 2'b01;
        tick();
        par_ctrl = 2'b00;
        check("t4_cleared", 32'(par_err), 32'd0);
        check("t4_lane_cleared", 32'(par_err_lane), 32'd0);
        check("t4_addr_cleared", 32'(par_err_addr), 32'd0);
        tick();
        check("t4_still_clear", 32'(par_err), 32'd0);
        wr(9'd9, 32'h0000_0001, 1'b0);
        rd(9'd9);
        wr(9'd7, 32'h0000_00FF, 1'b0);
        rd(9'd7);
        tick(); tick();
        check("t4_clean_rewrite", 32'(par_err), 32'd0);

        // T5: same-address write and read in one cycle
        wr(9'd3, 32'h0, 1'b0);
        we = 1'b1; wa = 9'd3; di = 32'hA5A5_A5A5; re = 1'b1; ra = 9'd3;
        exp_q.push_back(model[3]);
        tick();
        we = 1'b0; re = 1'b0;
        model[3] = 32'hA5A5_A5A5;
        check("t5_bypass0", dout, 32'h0);
        check("t5_bypass1", dout1, 32'hA5A5_A5A5);
        rd(9'd3);
        check("t5_readback1", dout1, 32'hA5A5_A5A5);
        tick(); tick();
        check("t5_err0", 32'(par_err), 32'd0);
        check("t5_err1", 32'(par_err1), 32'd0);

        // T6a: init request, user traffic and a second request during the sweep
        last_do = dout;
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        cnt = 0;
        while (init_busy === 1'b1 && cnt < 4 * DEPTH) begin
            if (cnt == 50) begin
                we = 1'b1; wa = 9'd5; di = 32'hDEAD_BEEF; re = 1'b1; ra = 9'd5;
            end
            if (cnt == 60) init_req = 1'b1;
            tick();
            cnt++;
            we = 1'b0; re = 1'b0; init_req = 1'b0;
            if (cnt == 51) begin
                check("t6_dvld_in_init", 32'(dvld), 32'd0);
                check("t6_do_hold", dout, last_do);
            end
        end
        check("t6_busy_cycles", 32'(cnt), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) model[i] = INIT_VAL;
        rd(9'd5);
        rd(9'd3);
        rd(ADDRBIT'(DEPTH - 1));
        rd(9'd0);
        tick(); tick();
        check("t6_no_err", 32'(par_err), 32'd0);

        // T6b: reset at ptr=100 restarts a full-length sweep
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (100) tick();
        rst_ = 1'b0;
        tick();
        check("t6_rst_busy", 32'(init_busy), 32'd1);
        check("t6_rst_do", dout, 32'h0);
        rst_ = 1'b1;
        wait_busy(cnt);
        check("t6_restart_cycles", 32'(cnt), 32'(DEPTH));
        rd(9'd100);
        rd(9'd250);
        tick(); tick(); tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
